// File: rtl/decode_execute_if.sv
// Fetch <-> decode/execute link: the instruction coming forward and the
// branch resolution going back to the fetch PC adder.
interface decode_execute_if;
  logic [7:0] Instruction_Code;
  logic       PCSrc;
  logic [7:0] X;

  // Fetch side presents instructions and consumes branch resolution.
  modport master (output Instruction_Code, input PCSrc, input X);
  // Decode/execute side latches instructions and resolves branches.
  modport slave  (input Instruction_Code, output PCSrc, output X);
endinterface

// File: rtl/decode_execute.sv
// Decode/execute stage of the 8-bit core: instruction register, 8x8 register
// file, single-cycle execute/writeback, BEQZ resolution with optional squash
// of the wrong-path instruction, and a retired-instruction counter.
module decode_execute #(
  parameter bit BRANCH_FLUSH = 1'b1
) (
  input  logic               Clk,
  input  logic               Reset,
  decode_execute_if.slave    fetch,
  input  logic [2:0]         Dbg_Sel,
  output logic [7:0]         Dbg_Data,
  output logic [7:0]         Instr_Count
);

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_ADD  = 2'b01,
    OP_LDI  = 2'b10,
    OP_BEQZ = 2'b11
  } op_e;

  logic [7:0] ir;
  logic       ir_v;
  logic [7:0] regs [8];
  logic [7:0] instr_count;

  op_e        op;
  logic [2:0] rd;
  logic [2:0] rs;
  logic [7:0] imm;
  logic [7:0] rd_val;
  logic [7:0] rs_val;
  logic       is_beqz;
  logic       take;
  logic       squash;
  logic       wr_en;
  logic [7:0] wr_data;

  // Field extraction from the held instruction.
  assign op      = op_e'(ir[7:6]);
  assign rd      = ir[5:3];
  assign rs      = ir[2:0];
  assign imm     = {{5{ir[2]}}, ir[2:0]};
  assign rd_val  = regs[rd];
  assign rs_val  = regs[rs];

  // Branch resolution: the held instruction is a valid BEQZ and its register is zero.
  assign is_beqz = ir_v && (op == OP_BEQZ);
  assign take    = is_beqz && (rd_val == 8'h00);
  assign squash  = BRANCH_FLUSH && take;

  assign fetch.PCSrc = take;
  assign fetch.X     = is_beqz ? imm : 8'h00;
  assign Dbg_Data    = regs[Dbg_Sel];
  assign Instr_Count = instr_count;

  // Writeback selection for the valid non-branch opcodes.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    wr_en   = 1'b0;
    wr_data = 8'h00;
    if (ir_v) begin
      case (op)
        OP_MOV:  begin wr_en = 1'b1; wr_data = rs_val;          end
        OP_ADD:  begin wr_en = 1'b1; wr_data = rd_val + rs_val; end
        OP_LDI:  begin wr_en = 1'b1; wr_data = imm;             end
        default: begin wr_en = 1'b0; wr_data = 8'h00;           end
      endcase
    end
  end

  // Register file: single write port, cleared by reset.
  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: the register file is reset explicitly because its contents are
    // architecturally visible (debug port, BEQZ on a never-written register),
    // so it must be a flop array rather than an unreset RAM.
    if (!Reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (wr_en) begin
      // NOTE: non-blocking so the read of regs[rd]/regs[rs] feeding this
      // write sees the pre-edge value; the result is visible next cycle.
      regs[rd] <= wr_data;
    end
  end

  // Instruction register, valid bit and retired-instruction counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ir          <= 8'h00;
      ir_v        <= 1'b0;
      instr_count <= 8'h00;
    end else begin
      if (ir_v) instr_count <= instr_count + 8'h01;
      if (squash) begin
        ir_v <= 1'b0;
      end else begin
        ir   <= fetch.Instruction_Code;
        ir_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_execute.sv
// Directed bench for decode_execute. The bench plays the fetch stage: a small
// program array and a PC that follows PCSrc/X exactly as the fetch adder would.
module tb_decode_execute;

  logic       Clk;
  logic       Reset;
  logic [2:0] Dbg_Sel;
  logic [7:0] Dbg_Data;
  logic [7:0] Instr_Count;

  decode_execute_if fetch ();

  decode_execute #(.BRANCH_FLUSH(1'b1)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .fetch       (fetch.slave),
    .Dbg_Sel     (Dbg_Sel),
    .Dbg_Data    (Dbg_Data),
    .Instr_Count (Instr_Count)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] prog [256];
  logic [7:0] pc;

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [7:0] exp);
    Dbg_Sel = 3'(idx);
    #1;
    check(tag, Dbg_Data, exp);
  endtask

  task automatic fill_prog(input logic [7:0] filler);
    for (int i = 0; i < 256; i++) prog[i] = filler;
  endtask

  // One clock of the fetch model: resolution sampled before the edge decides the next PC.
  task automatic step();
    logic       taken;
    logic [7:0] off;
    taken = fetch.PCSrc;
    off   = fetch.X;
    @(posedge Clk);
    #1;
    pc = taken ? pc + off : pc + 8'h01;
    fetch.Instruction_Code = prog[pc];
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset for three cycles with random garbage on the instruction bus, then release.
  task automatic do_reset();
    Reset = 1'b0;
    pc    = 8'h00;
    for (int i = 0; i < 3; i++) begin
      fetch.Instruction_Code = 8'($urandom);
      @(posedge Clk);
    end
    #1;
    Reset = 1'b1;
    fetch.Instruction_Code = prog[0];
  endtask

  initial begin
    Reset   = 1'b0;
    Dbg_Sel = 3'd0;
    fetch.Instruction_Code = 8'h00;
    fill_prog(8'h00);

    // Reset state while Reset is still held low.
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch.Instruction_Code = 8'($urandom);
      @(posedge Clk);
    end
    #1;
    check("rst_pcsrc", {7'd0, fetch.PCSrc}, 8'h00);
    check("rst_x", fetch.X, 8'h00);
    check("rst_count", Instr_Count, 8'h00);
    for (int i = 0; i < 8; i++) check_reg($sformatf("rst_reg%0d", i), i, 8'h00);

    // LDI r1,3 / LDI r2,-1 / ADD r1,r2 / MOV r3,r1
    fill_prog(8'h00);
    prog[0] = 8'h8B; prog[1] = 8'h97; prog[2] = 8'h4A; prog[3] = 8'h19;
    do_reset();
    steps(5);
    check("alu_count", Instr_Count, 8'h04);
    check_reg("alu_r1", 1, 8'h02);
    check_reg("alu_r2", 2, 8'hFF);
    check_reg("alu_r3", 3, 8'h02);

    // Mid-stream reset clears outputs in the same cycle.
    Reset = 1'b0;
    #1;
    check("midrst_count", Instr_Count, 8'h00);
    check_reg("midrst_r1", 1, 8'h00);
    check_reg("midrst_r2", 2, 8'h00);
    check("midrst_pcsrc", {7'd0, fetch.PCSrc}, 8'h00);

    // BEQZ taken: r4=0, BEQZ r4,+2 at address 5 -> target 8, wrong path skipped.
    fill_prog(8'h00);
    prog[0] = 8'hA0; prog[5] = 8'hE2; prog[6] = 8'hA9; prog[7] = 8'hB1; prog[8] = 8'hBB;
    do_reset();
    steps(6);
    check("tk_pcsrc", {7'd0, fetch.PCSrc}, 8'h01);
    check("tk_x", fetch.X, 8'h02);
    check("tk_count0", Instr_Count, 8'h05);
    step();
    check("tk_pc", pc, 8'h08);
    check("tk_count1", Instr_Count, 8'h06);
    check("tk_bubble_pcsrc", {7'd0, fetch.PCSrc}, 8'h00);
    step();
    check("tk_bubble_count", Instr_Count, 8'h06);
    check("tk_bubble_x", fetch.X, 8'h00);
    step();
    check("tk_count2", Instr_Count, 8'h07);
    check_reg("tk_r7", 7, 8'h03);
    check_reg("tk_r5", 5, 8'h00);
    check_reg("tk_r6", 6, 8'h00);

    // BEQZ not taken: r4=1, same branch falls through to address 6.
    prog[0] = 8'hA1;
    do_reset();
    steps(6);
    check("nt_pcsrc", {7'd0, fetch.PCSrc}, 8'h00);
    check("nt_x", fetch.X, 8'h02);
    check("nt_count0", Instr_Count, 8'h05);
    step();
    check("nt_pc", pc, 8'h07);
    step();
    check("nt_count2", Instr_Count, 8'h07);
    check_reg("nt_r5", 5, 8'h01);

    // Back-to-back: taken BEQZ at 1, BEQZ on zero reg at 2 is squashed.
    fill_prog(8'h00);
    prog[0] = 8'hA0; prog[1] = 8'hE2; prog[2] = 8'hE1; prog[3] = 8'hA9; prog[4] = 8'hB1;
    do_reset();
    steps(2);
    check("b2b_pcsrc0", {7'd0, fetch.PCSrc}, 8'h01);
    step();
    check("b2b_pcsrc1", {7'd0, fetch.PCSrc}, 8'h00);
    check("b2b_x1", fetch.X, 8'h00);
    check("b2b_pc", pc, 8'h04);
    step();
    check("b2b_pcsrc2", {7'd0, fetch.PCSrc}, 8'h00);
    check("b2b_count2", Instr_Count, 8'h02);
    step();
    check("b2b_count3", Instr_Count, 8'h03);
    check_reg("b2b_r6", 6, 8'h01);
    check_reg("b2b_r5", 5, 8'h00);

    // Self-loop: BEQZ r0,-1 at address 0 -> execute + bubble per iteration.
    fill_prog(8'h00);
    prog[0] = 8'hC7;
    do_reset();
    step();
    check("loop_pcsrc0", {7'd0, fetch.PCSrc}, 8'h01);
    check("loop_x0", fetch.X, 8'hFF);
    step();
    check("loop_pc", pc, 8'h00);
    check("loop_count1", Instr_Count, 8'h01);
    steps(2);
    check("loop_pcsrc2", {7'd0, fetch.PCSrc}, 8'h00);
    check("loop_count2", Instr_Count, 8'h02);

    // Counter wrap: 256 retired LDIs.
    fill_prog(8'h81);
    do_reset();
    steps(256);
    check("wrap_ff", Instr_Count, 8'hFF);
    step();
    check("wrap_00", Instr_Count, 8'h00);

    // ADD overflow: FF + 02 -> 01.
    fill_prog(8'h00);
    prog[0] = 8'h8F; prog[1] = 8'h92; prog[2] = 8'h4A;
    do_reset();
    steps(4);
    check_reg("addov_r1", 1, 8'h01);
    check_reg("addov_r2", 2, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_execute.md
# decode_execute

Second stage of the 8-bit core. It latches the `Instruction_Code` presented by the fetch stage into an instruction register. It then decodes and executes the held instruction against an 8×8-bit register file. It drives `PCSrc`/`X` back to the fetch stage to resolve branches, and squashes the wrong-path instruction after a taken branch.

## Interface
- `BRANCH_FLUSH`, default 1: when 1, the instruction latched on the edge that takes a branch is squashed. When 0, no squash (delay-slot semantics).
- `Clk` input 1: single clock, all state on rising edge.
- `Reset` input 1: asynchronous, active-low. Clears all state immediately.
- `Instruction_Code` input 8: instruction currently output by fetch.
- `PCSrc` output 1: 1 means fetch adds `X` to PC on the next edge; 0 means PC+1.
- `X` output 8: two's-complement branch offset.
- `Dbg_Sel` input 3: register file read-select for debug.
- `Dbg_Data` output 8: combinational read of `reg[Dbg_Sel]`.
- `Instr_Count` output 8: number of retired (valid, executed) instructions, wraps modulo 256.

## Operation
- **Instruction format:** `op=IR[7:6]`, `rd=IR[5:3]`, `rs=IR[2:0]`, `imm=sext(IR[2:0])` (range −4..+3, sign-extended to 8 bits).
- **Opcodes:**
  - `00` MOV: `reg[rd] <= reg[rs]`.
  - `01` ADD: `reg[rd] <= reg[rd]+reg[rs]` mod 256, no carry kept.
  - `10` LDI: `reg[rd] <= imm`.
  - `11` BEQZ: taken iff `reg[rd]==8'h00`. No register write.
- **State:** `IR[7:0]`, `IR_V`, `reg[0..7]`, `Instr_Count`. All registers are general-purpose; none are hardwired to zero.
- **Each rising edge, with `Reset` high:**
  - If `IR_V` and op≠11, write `reg[rd]`.
  - If `IR_V`, `Instr_Count <= Instr_Count+1`.
  - If `PCSrc==1` and `BRANCH_FLUSH==1`: `IR_V <= 0` and `IR` keeps any value.
  - Otherwise: `IR <= Instruction_Code` and `IR_V <= 1`.
- **Combinational outputs:**
  - `PCSrc = IR_V & (op==11) & (reg[rd]==0)`.
  - `X = (IR_V & op==11) ? imm : 8'h00`.
  - `X` is driven for not-taken BEQZ too; fetch ignores it.
- **A squashed slot:** performs no write, does not increment `Instr_Count`, and drives `PCSrc=0`.
- **Write ordering:** a register written on edge N is visible to the instruction executed in the following cycle. There is no forwarding hazard because execution and writeback happen at the same edge.

## Timing
- **Reset low:**
  - `IR=8'h00`, `IR_V=0`, all `reg=8'h00`, `Instr_Count=8'h00`.
  - Therefore `PCSrc=0`, `X=8'h00`, `Dbg_Data=8'h00`.
  - These values appear asynchronously, within the same cycle `Reset` falls.
- **First edges after reset:**
  - First rising edge after `Reset` rises: latches the instruction at address 0. Fetch PC moves to 1.
  - That instruction executes (writes or resolves) on the second edge.
- **Instruction latency:** 1 cycle from fetch-output to execute edge.
- **Branch target:** for BEQZ held at address A, fetch presents A+1 during its execute cycle. The taken target is A+1+imm, mod 256 via the fetch adder.
- **Taken-branch penalty:** 1 bubble cycle (`BRANCH_FLUSH=1`). The bubble cycle has `PCSrc=0`.
- **Consecutive branches:** a BEQZ at A+1 following a taken BEQZ at A is squashed and never evaluated.
- **Self-loop:** BEQZ with imm=−1 re-fetches itself, giving a 2-cycle loop (execute + bubble) while the condition holds.
- **Reset mid-operation:** the pending write or branch on that edge is lost. There are no partial updates.
- **`Instr_Count` wrap:** 8'hFF → 8'h00 with no flag.

## Test plan
- **Reset:** hold `Reset=0` with random `Instruction_Code` for 3 cycles → `PCSrc=0`, `X=00`, `Instr_Count=00`, and `Dbg_Data=00` for every `Dbg_Sel`. Assert `Reset=0` mid-stream → outputs clear in the same cycle.
- **LDI/ADD/MOV:**
  - Stream `10_001_011` (r1=3), `10_010_111` (r2=−1=FF), `01_001_010` (r1=r1+r2), `00_011_001` (r3=r1).
  - Required: r1=02, r2=FF, r3=02, `Instr_Count=04` two cycles after the last instruction is presented.
- **BEQZ taken:**
  - r4=00, instruction `11_100_010` at A=5.
  - Required: `PCSrc=1`, `X=02` in its execute cycle. Next cycle `IR_V=0`, no write, count unchanged. Fetch next presents address 8.
- **BEQZ not taken:** r4=01, same instruction → `PCSrc=0`, `X=02`, the following instruction is executed normally, and count increments by 2.
- **Back-to-back branches:** taken BEQZ immediately followed by BEQZ on a zero register → the second is squashed and produces no `PCSrc` pulse.
- **Wrap:** execute 256 LDIs → `Instr_Count` returns to 00. ADD FF+02 → 01.
